// File: rtl/trivium_pkg.sv
// trivium_pkg: shared states and constants for the Trivium stream controller.
package trivium_pkg;
  localparam int TRIVIUM_WARMUP_CYCLES = 1152;
  localparam int KS_BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    WAIT_RX,
    GEN,
    SEND
  } state_t;
endpackage

// File: rtl/trivium_ks_byte.sv
// trivium_ks_byte: collects 8 keystream bits LSB first; done pulses with the 8th step.
module trivium_ks_byte
  import trivium_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 ks_bit,
  output logic [KS_BYTE_W-1:0] ks_byte,
  output logic                 done
);
  localparam int IW = $clog2(KS_BYTE_W);
  logic [IW-1:0]        idx;
  logic [KS_BYTE_W-1:0] sh;
  assign done = en && idx == IW'(KS_BYTE_W - 1);
  // The final bit bypasses the register so the full byte is usable in the done cycle.
  always_comb begin
    ks_byte      = sh;
    ks_byte[idx] = ks_bit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      sh  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      sh[idx] <= ks_bit;
      idx     <= idx + 1'b1;
    end
endmodule

// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl: sequences key load, warm-up and per-byte keystream XOR between UART and Trivium core.
// Define TRIVIUM_STREAM_CTRL_PREFETCH_EN to prefetch the next keystream byte while the current one is sent.
module trivium_stream_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = TRIVIUM_WARMUP_CYCLES,
  parameter int CNT_W         = 11,
  parameter int BCNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              core_load,
  output logic              core_step,
  input  logic              core_ks,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              ready,
  output logic              busy,
  output logic [BCNT_W-1:0] byte_cnt
);
  state_t               state, state_nx;
  logic [CNT_W-1:0]     wcnt;
  logic [KS_BYTE_W-1:0] ks_byte, tx_next;
  logic                 ks_done, ks_en, warm_last, accept, tx_hs, tx_load;
  assign warm_last = state == WARMUP && wcnt == CNT_W'(WARMUP_CYCLES - 1);
  assign accept    = rx_valid && rx_ready;
  assign tx_hs     = tx_valid && tx_ready && !start;
  assign core_load = state == LOAD;
  assign busy      = state != IDLE;
  assign ks_en     = core_step && state != WARMUP;
`ifdef TRIVIUM_STREAM_CTRL_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
  logic [KS_BYTE_W-1:0] ks_buf;
  logic                 ks_full;
  // Refill runs in WAIT_RX alongside an outstanding transmit.
  assign core_step = state == WARMUP || state == GEN || (state == WAIT_RX && !ks_full);
  assign rx_ready  = state == WAIT_RX && ks_full && !tx_valid && !start;
  assign tx_load   = accept;
  assign tx_next   = rx_data ^ ks_buf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ks_buf  <= '0;
      ks_full <= 1'b0;
    end else begin
      if (ks_done) ks_buf <= ks_byte;
      ks_full <= !start && (ks_done || (ks_full && !accept));
    end
`else
  localparam bit PREFETCH = 1'b0;
  logic [7:0] rx_byte;
  assign core_step = state == WARMUP || state == GEN;
  assign rx_ready  = state == WAIT_RX && !start;
  assign tx_load   = state == GEN && ks_done && !start;
  assign tx_next   = rx_byte ^ ks_byte;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_byte <= '0;
    else if (accept) rx_byte <= rx_data;
`endif
  trivium_ks_byte u_ks (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .en     (ks_en),
    .ks_bit (core_ks),
    .ks_byte(ks_byte),
    .done   (ks_done)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      LOAD:    state_nx = WARMUP;
      WARMUP:  if (warm_last) state_nx = PREFETCH ? GEN : WAIT_RX;
      WAIT_RX: if (accept && !PREFETCH) state_nx = GEN;
      GEN:     if (ks_done) state_nx = PREFETCH ? WAIT_RX : SEND;
      SEND:    if (tx_hs) state_nx = WAIT_RX;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = LOAD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      ready    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nx;
      wcnt     <= (state == WARMUP && !warm_last && !start) ? wcnt + 1'b1 : '0;
      ready    <= !start && (ready || state_nx == WAIT_RX);
      tx_valid <= !start && (tx_load || (tx_valid && !tx_ready));
      if (tx_load) tx_data <= tx_next;
      byte_cnt <= start ? '0 : byte_cnt + BCNT_W'(tx_hs);
    end
endmodule

// File: doc/trivium_stream_ctrl.md
Name: trivium_stream_ctrl

Overview:
Sequencer between the UART byte interfaces and the Trivium keystream core inside trivium_top. It issues the key/IV load, runs the warm-up rounds, and gathers 8 keystream bits per byte, LSB first. It XORs each received byte with its keystream byte and hands the result to the UART transmitter over a valid/ready handshake.

Parameters:
WARMUP_CYCLES, 1152, core step count after load before keystream is valid
CNT_W, 11, width of warm-up counter (must hold WARMUP_CYCLES-1)
BCNT_W, 16, width of processed-byte counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; (re)key and initialise core
core_load  out  1  one-cycle pulse; core loads key/IV
core_step  out  1  core advances one round this cycle
core_ks  in  1  core keystream bit for current state; sampled when core_step=1
rx_valid  in  1  received byte available
rx_data  in  8  received byte
rx_ready  out  1  controller accepts rx byte this cycle
tx_valid  out  1  encrypted byte available
tx_data  out  8  rx byte XOR keystream byte
tx_ready  in  1  transmitter accepts byte
ready  out  1  warm-up complete; stream mode active
busy  out  1  high whenever state != IDLE
byte_cnt  out  BCNT_W  bytes delivered since last start; wraps to 0

Behaviour:
- Reset, async: state=IDLE; core_load, core_step, rx_ready, tx_valid, ready and busy=0; tx_data=0; byte_cnt=0; counters=0.
- States: IDLE, LOAD, WARMUP, WAIT_RX, GEN, SEND.
- IDLE: start -> LOAD.
- LOAD: core_load=1 for exactly one cycle -> WARMUP.
- WARMUP: core_step=1 every cycle, WARMUP_CYCLES cycles total. At the last step -> WAIT_RX. ready goes 1 in the first WAIT_RX cycle and stays 1 until reset or start.
- WAIT_RX: rx_ready=1. Accept on rx_valid&rx_ready, latch rx_data -> GEN.
- GEN: core_step=1 for 8 cycles. Bit k (k=0..7) of the keystream byte = core_ks on the k-th step. After the 8th step register tx_data = rx_byte XOR ks_byte -> SEND.
- SEND: tx_valid=1 with tx_data held stable until tx_ready. On handshake: byte_cnt+1 (wraps at 2^BCNT_W), tx_valid drops next cycle, go to WAIT_RX.
- Latency, base build: accept edge at cycle T; tx_valid high from T+9.
- core_step=0 in IDLE, LOAD, WAIT_RX, SEND. The keystream never advances without a consumer.
- start in any non-IDLE state aborts the current byte and goes to LOAD next cycle. Effects: tx_valid=0, ready=0, byte_cnt=0, and the pending rx byte is discarded without transmit. start has priority over every handshake in the same cycle.
- rx_valid while not in WAIT_RX is ignored; rx_ready stays 0.
- Reset mid-operation returns to the IDLE reset state at once. No core_load is issued until the next start.

Optional Feature:
TRIVIUM_STREAM_CTRL_PREFETCH_EN
- Defined:
  - A ks_buf register with a ks_full flag is added.
  - After warm-up, GEN fills ks_buf before the first WAIT_RX.
  - rx_ready = (state==WAIT_RX) & ks_full & !tx_valid.
  - On accept: tx_data = rx_data XOR ks_buf is registered, tx_valid rises at T+1, ks_full clears, and the next 8-step GEN runs in parallel with SEND.
  - Streaming throughput: one byte per max(9, tx handshake) cycles.
- Undefined: base behaviour above. ks_buf logic is absent.

Decomposition:
- Package trivium_pkg: state enum (6 encodings), TRIVIUM_WARMUP_CYCLES=1152, KS_BYTE_W=8.
- One sub-module, trivium_ks_byte: an 8-step bit collector with a step counter and a done pulse. It is used in GEN and in prefetch mode.

Test Plan:
- Warm-up count: start pulse -> core_load high exactly 1 cycle, then core_step high exactly 1152 consecutive cycles, ready=1 on the following cycle.
- Byte path (stub core_ks pattern 1,0,1,0,1,0,1,0): rx 0xA5 -> ks 0x55, tx_data 0xF0, tx_valid 9 cycles after accept (1 cycle with PREFETCH_EN), byte_cnt=1.
- Backpressure: hold tx_ready=0 for 20 cycles -> tx_valid/tx_data 0xF0 stable, rx_ready=0, core_step=0; release -> byte_cnt increments once.
- Ten-byte stream 0xA5,0x3C,0x7F,0xC1,0x99,0x42,0xE7,0xB8,0x5D,0xF0 with core_ks=0 -> tx bytes equal inputs, byte_cnt=10, total core_step=1152+80.
- start during GEN (step 4) -> tx_valid never rises for that byte, core_load pulses next cycle, byte_cnt=0, ready=0 until warm-up completes again.
- rst_n low mid-WARMUP -> all outputs reset asynchronously; after release no core_step until a new start.
